// File: rtl/ext_unit_pipe.sv
// Registered immediate / load-data extension unit for the MIPS datapath.
// Results are computed at the input and held in a 2-entry valid/ready FIFO.
module ext_unit_pipe #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  byte_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam int unsigned IMM_SH  = DATA_W - IMM_W;
  localparam int unsigned BYTE_SH = DATA_W - 8;
  localparam int unsigned HALF_SH = DATA_W - 16;

  typedef enum logic [2:0] {
    OP_SEXT = 3'd0,
    OP_ZEXT = 3'd1,
    OP_LUI  = 3'd2,
    OP_BOFF = 3'd3,
    OP_LB   = 3'd4,
    OP_LBU  = 3'd5,
    OP_LH   = 3'd6,
    OP_LHU  = 3'd7
  } op_t;

  logic [DATA_W-1:0] imm_z, imm_top, imm_sx;
  logic [DATA_W-1:0] byte_shift, half_shift;
  logic [DATA_W-1:0] byte_z, byte_sx, half_z, half_sx;
  logic [OFF_W-1:0]  off_even;
  logic [DATA_W-1:0] calc_result;
  logic              calc_err;

  // Sign extension is done by parking the field at the MSB and shifting back
  // arithmetically, which stays width-clean even when IMM_W equals DATA_W.
  always_comb begin
    imm_z      = DATA_W'(imm);
    imm_top    = imm_z << IMM_SH;
    imm_sx     = $signed(imm_top) >>> IMM_SH;
    off_even   = byte_off & ~OFF_W'(1);
    byte_shift = data >> {byte_off, 3'b000};
    half_shift = data >> {off_even, 3'b000};
    byte_z     = DATA_W'(byte_shift[7:0]);
    byte_sx    = $signed(byte_z << BYTE_SH) >>> BYTE_SH;
    half_z     = DATA_W'(half_shift[15:0]);
    half_sx    = $signed(half_z << HALF_SH) >>> HALF_SH;
  end

  always_comb begin
    calc_result = '0;
    calc_err    = 1'b0;
    case (op_t'(op))
      OP_SEXT: calc_result = imm_sx;
      OP_ZEXT: calc_result = imm_z;
      OP_LUI:  calc_result = imm_top;
      OP_BOFF: calc_result = imm_sx << 2;
      OP_LB:   calc_result = byte_sx;
      OP_LBU:  calc_result = byte_z;
      OP_LH, OP_LHU: begin
        if (byte_off[0]) begin
          calc_err = 1'b1;
        end else if (op_t'(op) == OP_LH) begin
          calc_result = half_sx;
        end else begin
          calc_result = half_z;
        end
      end
      default: calc_result = '0;
    endcase
  end

  logic [DATA_W-1:0] mem_result [2];
  logic [1:0]        mem_err;
  logic              head, tail;
  logic [1:0]        count;
  logic              push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign result    = mem_result[head];
  assign err       = mem_err[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_result[0] <= '0;
      mem_result[1] <= '0;
      mem_err       <= '0;
      head          <= 1'b0;
      tail          <= 1'b0;
      count         <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem_result[tail] <= calc_result;
        mem_err[tail]    <= calc_err;
        tail             <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: vector table, back-pressure, streaming,
// flush and asynchronous reset sequences against a queue scoreboard.
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  op;
  logic [15:0] imm;
  logic [31:0] data, result;
  logic [1:0]  byte_off;

  ext_unit_pipe #(.IMM_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .imm(imm), .data(data), .byte_off(byte_off),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] imm;
    logic [31:0] data;
    logic [1:0]  off;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t        vecs [10];
  logic [32:0] exp_q [$];
  logic [32:0] exp_in;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic        acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Independent reference written for the 16/32-bit configuration.
  function automatic logic [32:0] model(input logic [2:0] o, input logic [15:0] i,
                                        input logic [31:0] d, input logic [1:0] f);
    logic [31:0] r;
    logic        e;
    logic [7:0]  b;
    logic [15:0] h;
    r = 32'h0;
    e = 1'b0;
    case (f)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = f[1] ? d[31:16] : d[15:0];
    case (o)
      3'd0: r = {{16{i[15]}}, i};
      3'd1: r = {16'h0, i};
      3'd2: r = {i, 16'h0};
      3'd3: r = {{14{i[15]}}, i, 2'b00};
      3'd4: r = {{24{b[7]}}, b};
      3'd5: r = {24'h0, b};
      3'd6: if (f[0]) e = 1'b1; else r = {{16{h[15]}}, h};
      default: if (f[0]) e = 1'b1; else r = {16'h0, h};
    endcase
    return {e, r};
  endfunction

  task automatic drive_rand();
    op       = 3'($urandom_range(0, 7));
    imm      = 16'($urandom());
    data     = $urandom();
    byte_off = 2'($urandom_range(0, 3));
    exp_in   = model(op, imm, data, byte_off);
  endtask

  // Called mid-cycle with inputs set; scores the handshakes of the coming edge.
  task automatic cycle();
    logic [32:0] e;
    #1;
    acc = 1'b0;
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", result);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e[31:0]);
        chk("err", {31'b0, err}, {31'b0, e[32]});
        pops++;
      end
    end
    if (rst_n && in_valid && in_ready && !flush) begin
      exp_q.push_back(exp_in);
      acc = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      cycle();
      n++;
    end
    chk(name, exp_q.size(), 0);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, acc_n, n;
    vecs[0] = '{3'd0, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0};
    vecs[1] = '{3'd1, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0};
    vecs[2] = '{3'd2, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0};
    vecs[3] = '{3'd3, 16'h8001, 32'h0, 2'd0, 32'hFFFE0004, 1'b0};
    vecs[4] = '{3'd4, 16'h0, 32'h80F17F02, 2'd1, 32'h0000007F, 1'b0};
    vecs[5] = '{3'd4, 16'h0, 32'h80F17F02, 2'd3, 32'hFFFFFF80, 1'b0};
    vecs[6] = '{3'd5, 16'h0, 32'h80F17F02, 2'd2, 32'h000000F1, 1'b0};
    vecs[7] = '{3'd6, 16'h0, 32'h80F17F02, 2'd2, 32'hFFFF80F1, 1'b0};
    vecs[8] = '{3'd7, 16'h0, 32'h80F17F02, 2'd0, 32'h00007F02, 1'b0};
    vecs[9] = '{3'd6, 16'h0, 32'h80F17F02, 2'd1, 32'h00000000, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    op = 3'd1; imm = 16'h1234; data = 32'h0; byte_off = 2'd0; exp_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Vector table: each op alone, visible exactly one cycle after acceptance.
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      op = vecs[k].op; imm = vecs[k].imm; data = vecs[k].data; byte_off = vecs[k].off;
      exp_in = {vecs[k].err, vecs[k].res};
      in_valid = 1'b1;
      chk("vec_idle", {31'b0, out_valid}, 32'd0);
      cycle();
      in_valid = 1'b0;
      chk("vec_latency", {31'b0, out_valid}, 32'd1);
      cycle();
    end
    drain("vec_drain");

    // Back-pressure: two fill the buffer, the third waits for space.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_rand(); cycle();
    chk("bp_acc1", {31'b0, acc}, 32'd1);
    drive_rand(); cycle();
    chk("bp_acc2", {31'b0, acc}, 32'd1);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    drive_rand(); cycle();
    chk("bp_acc3_held", {31'b0, acc}, 32'd0);
    chk("bp_head_hold", result, exp_q[0][31:0]);
    cycle();
    chk("bp_head_hold2", result, exp_q[0][31:0]);
    out_ready = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10) begin
      cycle();
      n++;
    end
    chk("bp_acc3", {31'b0, acc}, 32'd1);
    drain("bp_drain");

    // Streaming: one op per cycle, output every cycle after the first.
    p0 = pops;
    acc_n = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      if (i > 0) chk("stream_valid", {31'b0, out_valid}, 32'd1);
      cycle();
      if (acc) acc_n++;
    end
    chk("stream_accepts", acc_n, 20);
    chk("stream_pops", pops - p0, 19);
    drain("stream_drain");

    // Flush with a full buffer and a pending input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_rand(); cycle();
    drive_rand(); cycle();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive_rand(); cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete();
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b1;
    drive_rand(); cycle();
    drain("fl_after");

    // Asynchronous reset between edges with two entries stored.
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd1; imm = 16'hBEEF; exp_in = model(op, imm, data, byte_off); cycle();
    op = 3'd0; imm = 16'hCAFE; exp_in = model(op, imm, data, byte_off); cycle();
    chk("ar_full", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
    chk("ar_result", result, 32'd0);
    chk("ar_err", {31'b0, err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("ar_idle_result", result, 32'd0);
    chk("ar_idle_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1;
    op = 3'd2; imm = 16'h00A5; exp_in = model(op, imm, data, byte_off); cycle();
    drain("ar_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
# ext_unit_pipe

Parametrised, registered extension unit for the pipelined MIPS datapath. It generalises the immediate extender to configurable widths and adds branch-offset and load-data extension modes (lb/lbu/lh/lhu) with misalignment detection. Results sit behind a 2-entry valid/ready buffer, so the unit can live between EX and MEM/WB and absorb downstream stalls without dropping operations.

## Interface
- IMM_W, 16: immediate width; 2 ≤ IMM_W ≤ DATA_W.
- DATA_W, 32: result and load-data width; a multiple of 16.
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; empties the buffer and discards the current input.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit can accept an input this cycle.
- op  in  3  mode; encodings are listed under Operation.
- imm  in  IMM_W  immediate operand for modes 0–3.
- data  in  DATA_W  memory word for modes 4–7.
- byte_off  in  OFF_W  byte address within `data` for modes 4–7.
- out_valid  out  1  `result` and `err` are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- result  out  DATA_W  extended value.
- err  out  1  misaligned halfword access for this result.

## Operation
- Modes:
  - 0: sign-extend `imm`.
  - 1: zero-extend `imm`.
  - 2: `imm` placed in the top IMM_W bits, low bits zero (LUI).
  - 3: sign-extend `imm`, then shift left 2 and truncate to DATA_W (branch offset).
  - 4: byte `data[8*byte_off +: 8]`, sign-extended.
  - 5: same byte, zero-extended.
  - 6: halfword `data[16*byte_off[OFF_W-1:1] +: 16]`, sign-extended.
  - 7: same halfword, zero-extended.
- Modes 6/7 with byte_off[0]=1 give result=0 and err=1. In every other case err=0.
- Byte numbering is little-endian: byte_off=0 selects data[7:0].
- `result` and `err` are computed combinationally at the input and written into the buffer. The output side never recomputes.
- The buffer is a 2-entry FIFO (head/tail pointers plus a count of 0..2):
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - in_ready = (count < 2). It does not depend on out_ready; there is no combinational ready path.
  - out_valid = (count > 0). result/err always show the head entry.
- When out_valid=1 and out_ready=0, result/err hold stable until the entry is popped.

## Timing
- Reset (asynchronous, rst_n=0): count=0, pointers=0, stored entries=0. Outputs: out_valid=0, in_ready=1, result=0, err=0.
- Release of rst_n takes effect at the next rising edge. No push is accepted during reset.
- Latency: an input accepted at edge N appears with out_valid=1 in the cycle after edge N, one cycle later.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous push and pop at count=1: count stays 1, and the new entry becomes head after the edge.
- At count=2 with out_ready=1: in_ready=0 this cycle, so only a pop occurs and the count becomes 1.
- At count=0 with push: out_valid rises next cycle. There is no same-cycle bypass.
- Pointers wrap modulo 2.
- flush=1 at an edge: count=0 and pointers=0 after the edge. Any in_valid in that cycle is dropped and no pop is counted. Stored data may remain, but out_valid=0.
- Reset asserted mid-stream clears everything immediately, regardless of clk.

## Test plan
- Reset then modes 0–3, DATA_W=32, imm=16'h8001: results 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004. Each appears one cycle after acceptance; err=0 for all four.
- Loads with data=32'h80F17F02:
  - op4 at off=1 → 32'h0000007F.
  - op4 at off=3 → 32'hFFFFFF80.
  - op5 at off=2 → 32'h000000F1.
  - op6 at off=2 → 32'hFFFF80F1.
  - op7 at off=0 → 32'h00007F02.
  - op6 at off=1 → result=0, err=1.
- Back-pressure: out_ready=0 and push 3 ops. in_ready falls after the 2nd, and the 3rd is held by the source. out_ready=1 then drains in order with no loss or duplication.
- Streaming: in_valid=out_ready=1 for 20 cycles gives 20 outputs in order, one per cycle, with count oscillating 0→1 and then steady at 1.
- Flush with count=2 and in_valid=1 gives out_valid=0 next cycle and in_ready=1. The flushed input never appears.
- rst_n pulsed low between clock edges while count=2 drops out_valid immediately; result=0 and err=0 until the first new push.
